// File: rtl/vend_credit_controller.sv
// Coin-operated vending credit controller: accumulates nickels/dimes/quarters, dispenses at PRICE, pays change.
// Optional coin-return (cancel) feature is enabled by defining COIN_RETURN_EN.
module vend_credit_controller #(
    parameter int PRICE    = 35,
    parameter int CREDIT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dimeDetected,
    input  logic                nickelDetected,
    input  logic                quarterDetected,
`ifdef COIN_RETURN_EN
    input  logic                cancel,
`endif
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense,
    output logic                dimeOut,
    output logic                nickelOut,
    output logic                coinReject,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] NICKEL  = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] DIME    = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] QUARTER = CREDIT_W'(25);

    state_t              state;
    state_t              state_next;
    logic [CREDIT_W-1:0] credit_next;
    logic                reject_next;
    logic [1:0]          pulse_count;
    logic                any_pulse;
    logic [CREDIT_W-1:0] coin_value;
    logic [CREDIT_W-1:0] coin_sum;
    logic                cancel_req;

`ifdef COIN_RETURN_EN
    assign cancel_req = cancel;
`else
    assign cancel_req = 1'b0;
`endif

    assign pulse_count = {1'b0, dimeDetected} + {1'b0, nickelDetected} + {1'b0, quarterDetected};
    assign any_pulse   = dimeDetected | nickelDetected | quarterDetected;

    // Value of the offered coin; only meaningful when exactly one pulse is present.
    always_comb begin
        coin_value = '0;
        if (dimeDetected)    coin_value = DIME;
        if (nickelDetected)  coin_value = NICKEL;
        if (quarterDetected) coin_value = QUARTER;
    end

    assign coin_sum = credit + coin_value;

    always_comb begin
        state_next  = state;
        credit_next = credit;
        reject_next = 1'b0;
        case (state)
            IDLE, COLLECT: begin
                if (pulse_count == 2'd1) begin
                    credit_next = coin_sum;
                    state_next  = (coin_sum >= PRICE_C) ? VEND : COLLECT;
                end else if (pulse_count > 2'd1) begin
                    reject_next = 1'b1;
                end else if (state == COLLECT && cancel_req) begin
                    state_next = CHANGE;
                end
            end
            VEND: begin
                reject_next = any_pulse;
                credit_next = credit - PRICE_C;
                state_next  = (credit == PRICE_C) ? IDLE : CHANGE;
            end
            CHANGE: begin
                reject_next = any_pulse;
                // Greedy change: dimes first, at most one trailing nickel.
                credit_next = credit - ((credit >= DIME) ? DIME : NICKEL);
                if (credit_next == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            credit     <= '0;
            coinReject <= 1'b0;
        end else begin
            state      <= state_next;
            credit     <= credit_next;
            coinReject <= reject_next;
        end
    end

    assign dispense  = (state == VEND);
    assign dimeOut   = (state == CHANGE) && (credit >= DIME);
    assign nickelOut = (state == CHANGE) && (credit < DIME);
    assign busy      = (state == VEND) || (state == CHANGE);

endmodule

// File: tb/tb_vend_credit_controller.sv
// Scoreboard bench for vend_credit_controller: a queue-based plan-of-actions model predicts outputs,
// a negedge monitor pops and compares. Exercises cancel when COIN_RETURN_EN is defined.
module tb_vend_credit_controller;

    localparam int PRICE    = 35;
    localparam int CREDIT_W = 8;
    localparam int ACT_DISPENSE = 1;
    localparam int ACT_DIME     = 2;
    localparam int ACT_NICKEL   = 3;

`ifdef COIN_RETURN_EN
    localparam bit CANCEL_EN = 1'b1;
`else
    localparam bit CANCEL_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                dimeDetected;
    logic                nickelDetected;
    logic                quarterDetected;
    logic                cancel;
    logic [CREDIT_W-1:0] credit;
    logic                dispense;
    logic                dimeOut;
    logic                nickelOut;
    logic                coinReject;
    logic                busy;

    always #5 clk = ~clk;

    vend_credit_controller #(.PRICE(PRICE), .CREDIT_W(CREDIT_W)) dut (
        .clk(clk),
        .reset(reset),
        .dimeDetected(dimeDetected),
        .nickelDetected(nickelDetected),
        .quarterDetected(quarterDetected),
`ifdef COIN_RETURN_EN
        .cancel(cancel),
`endif
        .credit(credit),
        .dispense(dispense),
        .dimeOut(dimeOut),
        .nickelOut(nickelOut),
        .coinReject(coinReject),
        .busy(busy)
    );

    typedef struct {
        int   credit;
        logic dispense;
        logic dime_out;
        logic nickel_out;
        logic coin_reject;
        logic busy;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: credit plus a queue of upcoming output actions, one per cycle.
    int   model_credit = 0;
    int   plan[$];
    logic model_reject = 1'b0;

    function automatic void planChange(input int amount);
        for (int i = 0; i < amount / 10; i++) plan.push_back(ACT_DIME);
        if (amount % 10 != 0) plan.push_back(ACT_NICKEL);
    endfunction

    function automatic int actionValue(input int act);
        if (act == ACT_DISPENSE) return PRICE;
        if (act == ACT_DIME)     return 10;
        return 5;
    endfunction

    function automatic void modelStep(input logic r, input logic d, input logic n,
                                      input logic q, input logic c);
        int cnt;
        int act;
        cnt = int'(d) + int'(n) + int'(q);
        if (r) begin
            model_credit = 0;
            plan.delete();
            model_reject = 1'b0;
        end else if (plan.size() > 0) begin
            model_reject = (cnt > 0);
            act = plan.pop_front();
            model_credit -= actionValue(act);
        end else begin
            model_reject = (cnt > 1);
            if (cnt == 1) begin
                model_credit += d ? 10 : (n ? 5 : 25);
                if (model_credit >= PRICE) begin
                    plan.push_back(ACT_DISPENSE);
                    planChange(model_credit - PRICE);
                end
            end else if (cnt == 0 && c && model_credit > 0) begin
                planChange(model_credit);
            end
        end
    endfunction

    function automatic exp_t modelOutputs();
        exp_t e;
        int   front;
        front         = (plan.size() > 0) ? plan[0] : 0;
        e.credit      = model_credit;
        e.dispense    = (front == ACT_DISPENSE);
        e.dime_out    = (front == ACT_DIME);
        e.nickel_out  = (front == ACT_NICKEL);
        e.coin_reject = model_reject;
        e.busy        = (plan.size() > 0);
        return e;
    endfunction

    task automatic applyStimulus(input logic r, input logic d, input logic n,
                                 input logic q, input logic c);
        reset           = r;
        dimeDetected    = d;
        nickelDetected  = n;
        quarterDetected = q;
        cancel          = c & CANCEL_EN;
        @(posedge clk);
        #1;
        modelStep(r, d, n, q, c & CANCEL_EN);
        exp_q.push_back(modelOutputs());
    endtask

    task automatic checkOutput(input exp_t e);
        vectors++;
        if (credit !== CREDIT_W'(e.credit) || dispense !== e.dispense || dimeOut !== e.dime_out ||
            nickelOut !== e.nickel_out || coinReject !== e.coin_reject || busy !== e.busy) begin
            miscompares++;
            $display("[TB] FAIL vec%0d got credit=%0d disp=%b dime=%b nick=%b rej=%b busy=%b, expected credit=%0d disp=%b dime=%b nick=%b rej=%b busy=%b",
                     vectors, credit, dispense, dimeOut, nickelOut, coinReject, busy,
                     e.credit, e.dispense, e.dime_out, e.nickel_out, e.coin_reject, e.busy);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    initial begin
        int sel;
        logic r;
        reset = 1'b1; dimeDetected = 1'b0; nickelDetected = 1'b0; quarterDetected = 1'b0; cancel = 1'b0;

        // Reset then idle.
        repeat (2) applyStimulus(1, 0, 0, 0, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0);

        // Exact price: quarter + dime.
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0);

        // Overpay with two quarters, coin offered during change.
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0);

        // Simultaneous coins rejected.
        applyStimulus(0, 1, 1, 0, 0);
        repeat (2) applyStimulus(0, 0, 0, 0, 0);

        // Reset while paying out 15 cents of change.
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0);

        // Coin return of 15 cents; cancel with a coin credits the coin instead.
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        repeat (3) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        repeat (2) applyStimulus(0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 99) < 2);
            sel = $urandom_range(0, 11);
            case (sel)
                4:       applyStimulus(r, 1, 0, 0, 0);
                5:       applyStimulus(r, 0, 1, 0, 0);
                6, 7:    applyStimulus(r, 0, 0, 1, 0);
                8:       applyStimulus(r, 1, 0, 1, 0);
                9:       applyStimulus(r, 1, 1, 1, 0);
                10:      applyStimulus(r, 0, 0, 0, 1);
                11:      applyStimulus(r, 0, 1, 0, 1);
                default: applyStimulus(r, 0, 0, 0, 0);
            endcase
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vend_credit_controller.md
VEND_CREDIT_CONTROLLER -- requirements
Module: vend_credit_controller

Interface
REQ-001 Parameter: PRICE, 35, product price in cents; multiple of 5, range 5..230.
REQ-002 Parameter: CREDIT_W, 8, width of credit register in bits.
REQ-003 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: dimeDetected  input  1  one-cycle pulse from upstream coin detector; worth 10 cents.
REQ-006 Port: nickelDetected  input  1  one-cycle pulse; worth 5 cents.
REQ-007 Port: quarterDetected  input  1  one-cycle pulse; worth 25 cents.
REQ-008 Port: credit  output  CREDIT_W  current accumulated credit in cents, registered.
REQ-009 Port: dispense  output  1  one-cycle product-release pulse.
REQ-010 Port: dimeOut  output  1  one-cycle pulse; eject one dime of change.
REQ-011 Port: nickelOut  output  1  one-cycle pulse; eject one nickel of change.
REQ-012 Port: coinReject  output  1  one-cycle pulse; offered coin not credited.
REQ-013 Port: busy  output  1  high while in VEND or CHANGE.

Function
REQ-014 The FSM SHALL have states IDLE, COLLECT, VEND, CHANGE; dispense, dimeOut, nickelOut, busy are Moore outputs of the registered state.
REQ-015 In IDLE or COLLECT, exactly one detect pulse SHALL add its value to credit at that rising edge (new credit visible next cycle).
REQ-016 At that edge, if the sum is >= PRICE the FSM SHALL go to VEND, else to COLLECT.
REQ-017 Two or more detect pulses in the same cycle SHALL credit nothing and pulse coinReject the following cycle.
REQ-018 Any detect pulse while in VEND or CHANGE SHALL credit nothing and pulse coinReject the following cycle.
REQ-019 VEND SHALL last exactly one cycle with dispense=1; on exit edge credit <= credit-PRICE; next state CHANGE if remainder > 0, else IDLE.
REQ-020 In CHANGE, each cycle SHALL assert dimeOut if credit >= 10 (credit -= 10 at edge), else nickelOut (credit -= 5 at edge); never both.
REQ-021 CHANGE SHALL exit to IDLE at the edge where credit becomes 0.
REQ-022 Latency: coin pulse at cycle n reaching PRICE gives dispense at cycle n+1 and first change pulse at cycle n+2.
REQ-023 Credit SHALL never exceed PRICE+20 and never underflow; no wrap-around possible in the legal PRICE range.

Reset
REQ-024 On reset high at a rising edge: state IDLE, credit 0, dispense/dimeOut/nickelOut/coinReject/busy 0.
REQ-025 Reset mid-VEND or mid-CHANGE SHALL discard the remaining credit with no further pulses; detect pulses coincident with reset are ignored.

Configuration
REQ-026 Macro COIN_RETURN_EN defined: add port cancel (input, 1, one-cycle pulse).
REQ-027 With COIN_RETURN_EN, cancel in COLLECT with no detect pulse SHALL go to CHANGE without dispense, refunding all credit.
REQ-028 With COIN_RETURN_EN, cancel with a coincident detect pulse is ignored (coin credited); cancel in IDLE, VEND, or CHANGE is ignored.
REQ-029 Without COIN_RETURN_EN: no cancel port; credit is held in COLLECT indefinitely.

Verification (PRICE=35)
REQ-030 Reset 2 cycles, idle 3 cycles -> credit=0, all pulse outputs 0, busy=0.
REQ-031 quarter, then dime -> credit 25 then 35; dispense 1 cycle; credit 0; IDLE; no change pulses.
REQ-032 quarter, quarter -> credit 50; dispense; credit 15; dimeOut (credit 5); nickelOut (credit 0); IDLE.
REQ-033 dime+nickel asserted same cycle -> coinReject 1 cycle, credit unchanged 0; quarter during CHANGE -> coinReject, credit unaffected.
REQ-034 COIN_RETURN_EN: dime, nickel, cancel -> dimeOut, nickelOut, no dispense, IDLE with credit 0.
REQ-035 Reset asserted during CHANGE with credit 15 -> next cycle credit 0, IDLE, no further dimeOut/nickelOut.
